// File: rtl/mmu_pkg.sv
// Shared MMU definitions: arbiter state encoding, default address width and page-entry field positions.
package mmu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } mmu_arb_state_e;

  localparam int MMU_AW        = 32;
  localparam int PTE_VALID_BIT = 0;
  localparam int PTE_FRAME_MSB = 31;
  localparam int PTE_FRAME_LSB = 12;

  function automatic logic pte_valid(input logic [MMU_AW-1:0] pte);
    return pte[PTE_VALID_BIT];
  endfunction

endpackage

// File: rtl/mmu_lookup_arbiter_rr_arbiter.sv
// Round-robin pick over N_REQ level requests; combinational grant, pointer moves to the winner on en_i.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic             vld_o,
  output logic [IW-1:0]    gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  logic          found;
  int            idx;

  // Search starts just after the last winner so it ends up lowest priority.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
  end

  assign vld_o = found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(N_REQ - 1);
    end else if (en_i && found) begin
      ptr_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/mmu_lookup_arbiter.sv
// Shares one MMU lookup port among N_REQ requesters, one lookup in flight, ack_o one cycle after mmu_ack_i.
// Optional MMU_ARB_TIMEOUT_EN adds an ack watchdog that answers with fault_o=1, ent_o=0.
module mmu_lookup_arbiter
  import mmu_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int AW             = MMU_AW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ*AW-1:0] addr_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic [AW-1:0]       ent_o,
  output logic                fault_o,
  output logic                busy_o,
  output logic [AW-1:0]       mmu_addr_o,
  output logic                mmu_lookup_o,
  input  logic [AW-1:0]       mmu_ent_i,
  input  logic                mmu_ack_i,
  input  logic                mmu_fault_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  mmu_arb_state_e state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [AW-1:0]  ent_q, ent_d;
  logic           fault_q, fault_d;
  logic           arb_en, arb_vld;
  logic [IW-1:0]  arb_idx;
`ifdef MMU_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]     cnt_q, cnt_d;
`endif

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .en_i     (arb_en),
    .vld_o    (arb_vld),
    .gnt_idx_o(arb_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    ent_d   = ent_q;
    fault_d = fault_q;
    arb_en  = 1'b0;
`ifdef MMU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          arb_en  = 1'b1;
          grant_d = arb_idx;
          addr_d  = addr_i[arb_idx*AW +: AW];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MMU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mmu_ack_i) begin
          ent_d   = mmu_ent_i;
          fault_d = mmu_fault_i;
          state_d = S_RESP;
        end
`ifdef MMU_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          ent_d   = '0;
          fault_d = 1'b1;
          state_d = S_RESP;
        end
        cnt_d = cnt_q + 8'd1;
`endif
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      ent_q   <= '0;
      fault_q <= 1'b0;
`ifdef MMU_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      ent_q   <= ent_d;
      fault_q <= fault_d;
`ifdef MMU_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    ack_o = '0;
    if (state_q == S_RESP) ack_o[grant_q] = 1'b1;
  end

  assign ent_o        = ent_q;
  assign fault_o      = fault_q;
  assign busy_o       = (state_q != S_IDLE);
  assign mmu_addr_o   = addr_q;
  assign mmu_lookup_o = (state_q == S_ISSUE);

endmodule
